mc6502_rmw_engine: RTL and testbench
====================================

Name: mc6502_rmw_engine

Overview:
Parametrised read-modify-write executor for memory-operand shift/rotate/increment/decrement instructions. It replaces the fixed 2-bit down-counter memory-to-memory path with an explicit state machine. Features: valid/ready request handshake, acknowledged memory store handshake, configurable NMOS-style dummy write, registered flag results. Sits between instruction decode (requests) and the memory controller (stores) / register file (flags).

Parameters:
DATA_W, 8, operand/result width in bits (>=2).
DUMMY_WRITE, 1, 1 = write unmodified operand before modified result (NMOS timing); 0 = single write.

Ports:
clk  input  1  clock
rst_x  input  1  reset, synchronous, active-high (name kept for codebase consistency; polarity fixed high)
i_valid  input  1  request valid
o_ready  output  1  engine idle, request accepted when i_valid & o_ready
i_op  input  3  operation: 0 ASL, 1 ROL, 2 LSR, 3 ROR, 4 INC, 5 DEC, 6/7 see Optional Feature
i_data  input  DATA_W  memory operand read by decode
i_a  input  DATA_W  accumulator value (used only by ops 6/7)
i_c  input  1  carry flag in
o_store  output  1  store request to memory controller
o_store_data  output  DATA_W  store data, stable while o_store high
i_store_ack  input  1  memory controller accepted current store
o_done  output  1  one-cycle completion pulse
o_n  output  1  N result, valid with o_done
o_z  output  1  Z result, valid with o_done
o_c  output  1  C result, valid with o_done
o_set_nz  output  1  update N and Z in register file (qualified by o_done)
o_set_z  output  1  update Z only (qualified by o_done)
o_set_c  output  1  update C (qualified by o_done)

Behaviour:
- States: IDLE, MODIFY, DUMMY_WR, FINAL_WR, DONE. All outputs registered or decoded from the state register.
- Reset: state=IDLE. o_ready=1. o_store=0. o_store_data=0. o_done=0. o_n/o_z/o_c=0. All set strobes 0.
- Reset mid-operation: return to IDLE next cycle. o_store drops immediately. No o_done. Pending store abandoned.
- IDLE: o_ready=1. On i_valid, latch i_op, i_data, i_a, i_c and go to MODIFY. i_valid outside IDLE is ignored; there is no queueing.
- MODIFY: compute the result into a register, with flags. Next state is DUMMY_WR if DUMMY_WRITE=1, else FINAL_WR.
- DUMMY_WR: o_store=1, o_store_data=latched operand. Hold until i_store_ack, then go to FINAL_WR.
- FINAL_WR: o_store=1, o_store_data=result. Hold until i_store_ack, then go to DONE.
- i_store_ack sampled high in the same cycle o_store is first asserted counts. Ack while o_store=0 is ignored.
- DONE: o_done=1 for exactly one cycle with flags and strobes, then IDLE. o_ready returns the cycle after DONE.
- Latency with immediate ack: accept at T, o_done at T+4 (DUMMY_WRITE=1) or T+3 (DUMMY_WRITE=0). Back-to-back throughput is one op per 5 / 4 cycles.
- Arithmetic (W=DATA_W, MSB=bit W-1):
  - ASL: r={d[W-2:0],0}, C=d[W-1].
  - ROL: r={d[W-2:0],c}, C=d[W-1].
  - LSR: r={0,d[W-1:1]}, C=d[0].
  - ROR: r={c,d[W-1:1]}, C=d[0].
  - INC: r=d+1 mod 2^W.
  - DEC: r=d-1 mod 2^W.
  - No decimal mode.
- Flags:
  - N=r[W-1], Z=(r==0).
  - Shifts/rotates: o_set_nz=1, o_set_c=1.
  - INC/DEC: o_set_nz=1, o_set_c=0, o_c=0.
- Wrap: INC all-ones -> 0 with Z=1, N=0. DEC 0 -> all-ones with N=1, Z=0.
- Ops 6/7 without the optional feature: reserved. Writes store the operand unmodified; o_done pulses with all set strobes 0.

Optional Feature:
MC6502_RMW_TSB_TRB_EN:
- Defined: op 6=TSB, r=d|a. Op 7=TRB, r=d&~a.
- For both: o_z=((a&d)==0), o_set_z=1, o_set_nz=0, o_set_c=0. Store sequence unchanged.
- Undefined: ops 6/7 reserved as above. o_set_z is tied 0 and i_a is unused.

Test Plan:
- DATA_W=8, DUMMY_WRITE=1, ack always 1; ASL d=0x81 -> stores 0x81 then 0x02; o_done at T+4 with N=0, Z=0, C=1, set_nz=1, set_c=1.
- ROR d=0x01, c=0 -> single final store 0x00, Z=1, C=1. With DUMMY_WRITE=0, o_done at T+3 and exactly one o_store cycle.
- INC d=0xFF -> 0x00, Z=1, set_c=0. DEC d=0x00 -> 0xFF, N=1. Repeat with DATA_W=16: INC 0xFFFF -> 0x0000.
- ROL d=0x40, c=1; ack withheld 3 cycles in DUMMY_WR -> o_store_data holds 0x40 all 3 cycles, then 0x81; o_done one cycle only. i_valid held throughout accepted only once.
- Assert rst_x during FINAL_WR -> o_store=0 next cycle, no o_done, o_ready=1; new INC d=0x10 afterwards completes with 0x11.
- With MC6502_RMW_TSB_TRB_EN: TSB d=0x0F, a=0xF0 -> 0xFF, Z=1, set_z=1, set_nz=0. TRB d=0xFF, a=0x0F -> 0xF0, Z=0. Without the macro, op 6 -> stores 0x0F, all strobes 0.

Source files
------------

// File: rtl/mc6502_rmw_engine.sv
// ---------------------------------------------------------------------------
// mc6502_rmw_engine
//
// Read-modify-write executor for memory-operand shift, rotate, increment and
// decrement instructions. Decode hands over the already-read operand through
// a valid/ready handshake. The engine computes the result and flags and
// issues one or two acknowledged stores to the memory controller. It then
// pulses o_done with the flag results and update strobes for the register
// file.
//
// Sequence: IDLE -> MODIFY -> [DUMMY_WR] -> FINAL_WR -> DONE -> IDLE
//   DUMMY_WR (DUMMY_WRITE=1 only) stores the unmodified operand first, which
//   reproduces the NMOS double-write bus behaviour.
//
// Parameters:
//   DATA_W       operand/result width in bits (>= 2)
//   DUMMY_WRITE  1 = write operand, then result; 0 = write result only
//
// Optional feature macro: MC6502_RMW_TSB_TRB_EN
//   Defined   : op 6 = TSB (d | a), op 7 = TRB (d & ~a), Z from (a & d),
//               only o_set_z strobed.
//   Undefined : ops 6/7 are reserved. They store the operand unchanged and
//               strobe no flags. i_a is unused and o_set_z is always 0.
//
// Ports:
//   clk, rst_x          clock, synchronous active-high reset
//   i_valid / o_ready   request handshake (accepted when both high)
//   i_op                0 ASL, 1 ROL, 2 LSR, 3 ROR, 4 INC, 5 DEC, 6/7 TSB/TRB
//   i_data, i_a, i_c    operand, accumulator, carry in (latched on accept)
//   o_store             store request, held until i_store_ack
//   o_store_data        store data, stable while o_store is high
//   i_store_ack         memory controller accepted the current store
//   o_done              one-cycle completion pulse
//   o_n, o_z, o_c       flag results, valid with o_done
//   o_set_nz/z/c        register-file update strobes, valid with o_done
// ---------------------------------------------------------------------------
module mc6502_rmw_engine #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DUMMY_WRITE = 1
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_c,
  output logic              o_store,
  output logic [DATA_W-1:0] o_store_data,
  input  logic              i_store_ack,
  output logic              o_done,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c,
  output logic              o_set_nz,
  output logic              o_set_z,
  output logic              o_set_c
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MODIFY   = 3'd1,
    DUMMY_WR = 3'd2,
    FINAL_WR = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [2:0] OP_ASL = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_LSR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_DEC = 3'd5;
`ifdef MC6502_RMW_TSB_TRB_EN
  localparam logic [2:0] OP_TSB = 3'd6;
  localparam logic [2:0] OP_TRB = 3'd7;
`endif

  // Result word plus everything the register file needs at completion.
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              n;
    logic              z;
    logic              c;
    logic              set_nz;
    logic              set_z;
    logic              set_c;
  } rmw_t;

  // Shift/rotate/inc/dec core. Reserved opcodes pass the operand through
  // with no strobes, so the store sequence still runs but flags stay intact.
  function automatic rmw_t rmw_calc(input logic [2:0]        op,
                                    input logic [DATA_W-1:0] d,
                                    input logic              cin);
    rmw_t res;
    res   = '0;
    res.r = d;
    case (op)
      OP_ASL: begin
        res.r      = {d[DATA_W-2:0], 1'b0};
        res.c      = d[DATA_W-1];
        res.set_nz = 1'b1;
        res.set_c  = 1'b1;
      end
      OP_ROL: begin
        res.r      = {d[DATA_W-2:0], cin};
        res.c      = d[DATA_W-1];
        res.set_nz = 1'b1;
        res.set_c  = 1'b1;
      end
      OP_LSR: begin
        res.r      = {1'b0, d[DATA_W-1:1]};
        res.c      = d[0];
        res.set_nz = 1'b1;
        res.set_c  = 1'b1;
      end
      OP_ROR: begin
        res.r      = {cin, d[DATA_W-1:1]};
        res.c      = d[0];
        res.set_nz = 1'b1;
        res.set_c  = 1'b1;
      end
      OP_INC: begin
        res.r      = d + DATA_W'(1);
        res.set_nz = 1'b1;
      end
      OP_DEC: begin
        res.r      = d - DATA_W'(1);
        res.set_nz = 1'b1;
      end
      default: ;
    endcase
    res.n = res.r[DATA_W-1];
    res.z = (res.r == '0);
    return res;
  endfunction

  state_t            state_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              cin_q;
  rmw_t              res_q;
  rmw_t              alu_d;

  logic              ready_q;
  logic              store_q;
  logic [DATA_W-1:0] store_data_q;
  logic              done_q;
  logic              flag_n_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic              set_nz_q;
  logic              set_z_q;
  logic              set_c_q;

`ifdef MC6502_RMW_TSB_TRB_EN
  logic [DATA_W-1:0] a_q;
`else
  logic              unused_a;
  assign unused_a = ^i_a;
`endif

  always_comb begin
    alu_d = rmw_calc(op_q, data_q, cin_q);
`ifdef MC6502_RMW_TSB_TRB_EN
    // TSB/TRB report Z from the bit test (a & d), not from the result.
    if (op_q == OP_TSB || op_q == OP_TRB) begin
      alu_d.r      = (op_q == OP_TSB) ? (data_q | a_q) : (data_q & ~a_q);
      alu_d.n      = alu_d.r[DATA_W-1];
      alu_d.z      = ((data_q & a_q) == '0);
      alu_d.c      = 1'b0;
      alu_d.set_nz = 1'b0;
      alu_d.set_z  = 1'b1;
      alu_d.set_c  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      store_q      <= 1'b0;
      store_data_q <= '0;
      done_q       <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      set_nz_q     <= 1'b0;
      set_z_q      <= 1'b0;
      set_c_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_q    <= i_op;
            data_q  <= i_data;
            cin_q   <= i_c;
`ifdef MC6502_RMW_TSB_TRB_EN
            a_q     <= i_a;
`endif
            ready_q <= 1'b0;
            state_q <= MODIFY;
          end
        end
        MODIFY: begin
          res_q   <= alu_d;
          store_q <= 1'b1;
          if (DUMMY_WRITE != 0) begin
            state_q      <= DUMMY_WR;
            store_data_q <= data_q;
          end else begin
            state_q      <= FINAL_WR;
            store_data_q <= alu_d.r;
          end
        end
        DUMMY_WR: begin
          // o_store stays high across the switch to the result write.
          if (i_store_ack) begin
            state_q      <= FINAL_WR;
            store_data_q <= res_q.r;
          end
        end
        FINAL_WR: begin
          if (i_store_ack) begin
            state_q  <= DONE;
            store_q  <= 1'b0;
            done_q   <= 1'b1;
            flag_n_q <= res_q.n;
            flag_z_q <= res_q.z;
            flag_c_q <= res_q.c;
            set_nz_q <= res_q.set_nz;
            set_z_q  <= res_q.set_z;
            set_c_q  <= res_q.set_c;
          end
        end
        DONE: begin
          // Strobes are dropped so they are only ever high alongside o_done.
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          set_nz_q <= 1'b0;
          set_z_q  <= 1'b0;
          set_c_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          store_q  <= 1'b0;
          set_nz_q <= 1'b0;
          set_z_q  <= 1'b0;
          set_c_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_store      = store_q;
  assign o_store_data = store_data_q;
  assign o_done       = done_q;
  assign o_n          = flag_n_q;
  assign o_z          = flag_z_q;
  assign o_c          = flag_c_q;
  assign o_set_nz     = set_nz_q;
  assign o_set_z      = set_z_q;
  assign o_set_c      = set_c_q;

endmodule

// File: tb/tb_mc6502_rmw_engine.sv
// ---------------------------------------------------------------------------
// Testbench for mc6502_rmw_engine.
//   u_a : DATA_W=8,  DUMMY_WRITE=1 (scoreboard-checked every cycle)
//   u_b : DATA_W=16, DUMMY_WRITE=0 (directed checks)
// ---------------------------------------------------------------------------
module tb_mc6502_rmw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_x;

  logic       iv_a, c_a, ack_a;
  logic [2:0] op_a;
  logic [7:0] d_a, a_a;
  logic       rdy_a, st_a, dn_a, n_a, z_a, cf_a, snz_a, sz_a, sc_a;
  logic [7:0] sd_a;

  logic        iv_b, c_b, ack_b;
  logic [2:0]  op_b;
  logic [15:0] d_b, a_b;
  logic        rdy_b, st_b, dn_b, n_b, z_b, cf_b, snz_b, sz_b, sc_b;
  logic [15:0] sd_b;

  mc6502_rmw_engine #(.DATA_W(8), .DUMMY_WRITE(1)) u_a (
    .clk(clk), .rst_x(rst_x), .i_valid(iv_a), .o_ready(rdy_a), .i_op(op_a),
    .i_data(d_a), .i_a(a_a), .i_c(c_a), .o_store(st_a), .o_store_data(sd_a),
    .i_store_ack(ack_a), .o_done(dn_a), .o_n(n_a), .o_z(z_a), .o_c(cf_a),
    .o_set_nz(snz_a), .o_set_z(sz_a), .o_set_c(sc_a));

  mc6502_rmw_engine #(.DATA_W(16), .DUMMY_WRITE(0)) u_b (
    .clk(clk), .rst_x(rst_x), .i_valid(iv_b), .o_ready(rdy_b), .i_op(op_b),
    .i_data(d_b), .i_a(a_b), .i_c(c_b), .o_store(st_b), .o_store_data(sd_b),
    .i_store_ack(ack_b), .o_done(dn_b), .o_n(n_b), .o_z(z_b), .o_c(cf_b),
    .o_set_nz(snz_b), .o_set_z(sz_b), .o_set_c(sc_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] r;
    logic        n, z, c, snz, sz, sc;
    logic [2:0]  op;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op, input int d, input int a,
                                 input int c, input int w);
    exp_t e;
    int   mask, half, r, cf;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    r = d; cf = 0;
    e.snz = 0; e.sz = 0; e.sc = 0; e.op = op;
    case (op)
      3'd0: begin r = (d * 2) & mask;     cf = d / half; e.snz = 1; e.sc = 1; end
      3'd1: begin r = (d * 2 + c) & mask; cf = d / half; e.snz = 1; e.sc = 1; end
      3'd2: begin r = d / 2;              cf = d % 2;    e.snz = 1; e.sc = 1; end
      3'd3: begin r = d / 2 + c * half;   cf = d % 2;    e.snz = 1; e.sc = 1; end
      3'd4: begin r = (d + 1) & mask;     e.snz = 1; end
      3'd5: begin r = (d + mask) & mask;  e.snz = 1; end
`ifdef MC6502_RMW_TSB_TRB_EN
      3'd6: begin r = (d | a) & mask;     e.sz = 1; end
      3'd7: begin r = d & (~a) & mask;    e.sz = 1; end
`endif
      default: r = d;
    endcase
    e.r = r[15:0];
    e.n = (r >= half);
    e.z = (r == 0);
    e.c = cf[0];
`ifdef MC6502_RMW_TSB_TRB_EN
    if (op >= 3'd6) e.z = ((d & a) == 0);
`endif
    return e;
  endfunction

  // ---------------- scoreboard for u_a ----------------
  exp_t        q_done[$];
  logic [7:0]  q_st[$];
  bit          m_busy = 0, m_rel = 0;
  exp_t        ce;

  always @(negedge clk) begin
    if (rst_x) begin
      q_done.delete(); q_st.delete(); m_busy = 0; m_rel = 0;
    end else begin
      if (m_rel) begin m_busy = 0; m_rel = 0; end
      chk("sb_ready", rdy_a, !m_busy);
      if (st_a) begin
        if (q_st.size() == 0) chk("sb_store_unexpected", st_a, 0);
        else begin
          chk("sb_store_data", sd_a, q_st[0]);
          if (ack_a) void'(q_st.pop_front());
        end
      end
      if (dn_a) begin
        if (q_done.size() == 0) chk("sb_done_unexpected", dn_a, 0);
        else begin
          ce = q_done.pop_front();
          chk("sb_stores_left", q_st.size(), 0);
          chk("sb_set_nz", snz_a, ce.snz);
          chk("sb_set_z", sz_a, ce.sz);
          chk("sb_set_c", sc_a, ce.sc);
          if (ce.snz || ce.sz) chk("sb_z", z_a, ce.z);
          if (ce.snz) chk("sb_n", n_a, ce.n);
          if (ce.sc || ce.op == 3'd4 || ce.op == 3'd5) chk("sb_c", cf_a, ce.c);
          m_rel = 1;
        end
      end
      if (!m_busy && iv_a) begin
        ce = model(op_a, int'(d_a), int'(a_a), int'(c_a), 8);
        q_st.push_back(d_a);
        q_st.push_back(ce.r[7:0]);
        q_done.push_back(ce);
        m_busy = 1;
      end
    end
  end

  // ---------------- directed run helper ----------------
  int          sel = 0;
  logic        v_done, v_st, v_n, v_z, v_c, v_snz, v_sz, v_sc;
  logic [15:0] v_sd;
  assign v_done = (sel != 0) ? dn_b  : dn_a;
  assign v_st   = (sel != 0) ? st_b  : st_a;
  assign v_sd   = (sel != 0) ? sd_b  : {8'h00, sd_a};
  assign v_n    = (sel != 0) ? n_b   : n_a;
  assign v_z    = (sel != 0) ? z_b   : z_a;
  assign v_c    = (sel != 0) ? cf_b  : cf_a;
  assign v_snz  = (sel != 0) ? snz_b : snz_a;
  assign v_sz   = (sel != 0) ? sz_b  : sz_a;
  assign v_sc   = (sel != 0) ? sc_b  : sc_a;

  int          cap_lat, cap_ns;
  logic [15:0] cap_st[$];
  logic        cap_n, cap_z, cap_c, cap_snz, cap_sz, cap_sc;

  function automatic logic [15:0] st_at(input int i);
    if (i < cap_st.size()) return cap_st[i];
    return 16'hDEAD;
  endfunction

  // Issue one op with ack held high; latency counted from the accept cycle.
  task automatic run(input int s, input logic [2:0] op, input logic [15:0] d,
                     input logic [15:0] a, input logic c);
    sel = s; cap_lat = -1; cap_ns = 0; cap_st.delete();
    @(posedge clk); #1;
    if (s == 0) begin iv_a = 1; op_a = op; d_a = d[7:0]; a_a = a[7:0]; c_a = c; end
    else        begin iv_b = 1; op_b = op; d_b = d;      a_b = a;      c_b = c; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (v_done) begin
        cap_lat = k; cap_n = v_n; cap_z = v_z; cap_c = v_c;
        cap_snz = v_snz; cap_sz = v_sz; cap_sc = v_sc;
        break;
      end
      if (v_st) begin cap_ns++; cap_st.push_back(v_sd); end
      @(posedge clk); #1;
      iv_a = 0; iv_b = 0;
    end
    if (cap_lat < 0) chk("run_timeout", v_done, 1);
  endtask

  exp_t me;
  int   stall, d1, d2, got;
  logic [7:0] stl[$];

  initial begin
    rst_x = 1; iv_a = 0; op_a = 0; d_a = 0; a_a = 0; c_a = 0; ack_a = 1;
    iv_b = 0; op_b = 0; d_b = 0; a_b = 0; c_b = 0; ack_b = 1;

    // Pin the model with hand-computed values.
    me = model(3'd0, 'h81, 0, 0, 8);   chk("model_asl", me.r, 16'h0002);
    me = model(3'd3, 'h01, 0, 1, 8);   chk("model_ror", me.r, 16'h0080);
    me = model(3'd5, 0, 0, 0, 16);     chk("model_dec16", me.r, 16'hFFFF);

    repeat (3) @(posedge clk); #1;
    chk("rst_ready", rdy_a, 1); chk("rst_store", st_a, 0);
    chk("rst_store_data", sd_a, 0); chk("rst_done", dn_a, 0);
    chk("rst_nzc", {n_a, z_a, cf_a}, 0);
    chk("rst_strobes", {snz_a, sz_a, sc_a}, 0);
    chk("rst_b_ready", rdy_b, 1); chk("rst_b_store", st_b, 0);
    rst_x = 0;

    // ASL 0x81
    run(0, 3'd0, 16'h81, 0, 0);
    chk("asl_latency", cap_lat, 4); chk("asl_nstores", cap_ns, 2);
    chk("asl_st0", st_at(0), 16'h81); chk("asl_st1", st_at(1), 16'h02);
    chk("asl_nzc", {cap_n, cap_z, cap_c}, 3'b001);
    chk("asl_strobes", {cap_snz, cap_sz, cap_sc}, 3'b101);
    // ROR 0x01, c=0
    run(0, 3'd3, 16'h01, 0, 0);
    chk("ror_st1", st_at(1), 16'h00); chk("ror_zc", {cap_z, cap_c}, 2'b11);
    // INC 0xFF, DEC 0x00
    run(0, 3'd4, 16'hFF, 0, 0);
    chk("inc_st1", st_at(1), 16'h00); chk("inc_nz", {cap_n, cap_z}, 2'b01);
    chk("inc_set_c", cap_sc, 0);
    run(0, 3'd5, 16'h00, 0, 0);
    chk("dec_st1", st_at(1), 16'hFF); chk("dec_nz", {cap_n, cap_z}, 2'b10);
    // Ops 6/7
`ifdef MC6502_RMW_TSB_TRB_EN
    run(0, 3'd6, 16'h0F, 16'hF0, 0);
    chk("tsb_st1", st_at(1), 16'hFF); chk("tsb_z", cap_z, 1);
    chk("tsb_strobes", {cap_snz, cap_sz, cap_sc}, 3'b010);
    run(0, 3'd7, 16'hFF, 16'h0F, 0);
    chk("trb_st1", st_at(1), 16'hF0); chk("trb_z", cap_z, 0);
    chk("trb_strobes", {cap_snz, cap_sz, cap_sc}, 3'b010);
`else
    run(0, 3'd6, 16'h0F, 16'hF0, 0);
    chk("rsv_st0", st_at(0), 16'h0F); chk("rsv_st1", st_at(1), 16'h0F);
    chk("rsv_strobes", {cap_snz, cap_sz, cap_sc}, 3'b000);
`endif

    // Back-to-back: valid held, two completions five cycles apart.
    sel = 0; d1 = -1; d2 = -1;
    @(posedge clk); #1; iv_a = 1; op_a = 3'd2; d_a = 8'h02; c_a = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (dn_a) begin
        if (d1 < 0) d1 = k;
        else begin d2 = k; iv_a = 0; break; end
      end
    end
    iv_a = 0;
    chk("b2b_spacing", d2 - d1, 5);

    // ROL 0x40 c=1, ack withheld 3 cycles in DUMMY_WR, valid held throughout.
    stl.delete(); stall = 0; got = 0;
    @(posedge clk); #1; ack_a = 0; iv_a = 1; op_a = 3'd1; d_a = 8'h40; c_a = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (st_a) begin stl.push_back(sd_a); if (!ack_a) stall++; end
      if (dn_a) begin iv_a = 0; got = 1; break; end
      @(posedge clk); #1;
      ack_a = (stall >= 3);
    end
    iv_a = 0;
    chk("stall_done", dn_a, got);
    chk("stall_nstores", stl.size(), 5);
    if (stl.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("stall_dummy_data", stl[i], 8'h40);
      chk("stall_final_data", stl[4], 8'h81);
    end
    @(negedge clk);
    chk("stall_done_one_cycle", dn_a, 0); chk("stall_ready_after", rdy_a, 1);
    repeat (3) begin @(negedge clk); chk("stall_no_reaccept", rdy_a, 1); end

    // Reset during FINAL_WR of DEC 0x22 (final store 0x21).
    got = 0; ack_a = 1;
    @(posedge clk); #1; iv_a = 1; op_a = 3'd5; d_a = 8'h22; c_a = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      iv_a = 0;
      if (st_a && sd_a == 8'h21) begin ack_a = 0; got = 1; break; end
    end
    chk("rstmid_reached_final", st_a, got);
    rst_x = 1;
    @(posedge clk); #1;
    rst_x = 0;
    chk("rstmid_store", st_a, 0); chk("rstmid_ready", rdy_a, 1);
    chk("rstmid_done", dn_a, 0);
    repeat (4) begin @(negedge clk); chk("rstmid_no_done", dn_a, 0); end
    ack_a = 1;
    run(0, 3'd4, 16'h10, 0, 0);
    chk("rstmid_inc_st1", st_at(1), 16'h11); chk("rstmid_inc_lat", cap_lat, 4);

    // 16-bit, no dummy write
    run(1, 3'd4, 16'hFFFF, 0, 0);
    chk("b_inc_lat", cap_lat, 3); chk("b_inc_nstores", cap_ns, 1);
    chk("b_inc_st0", st_at(0), 16'h0000); chk("b_inc_nz", {cap_n, cap_z}, 2'b01);
    chk("b_inc_strobes", {cap_snz, cap_sz, cap_sc}, 3'b100);
    run(1, 3'd3, 16'h0001, 0, 0);
    chk("b_ror_lat", cap_lat, 3); chk("b_ror_nstores", cap_ns, 1);
    chk("b_ror_st0", st_at(0), 16'h0000); chk("b_ror_zc", {cap_z, cap_c}, 2'b11);
    run(1, 3'd5, 16'h0000, 0, 0);
    chk("b_dec_st0", st_at(0), 16'hFFFF); chk("b_dec_nz", {cap_n, cap_z}, 2'b10);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
